// File: rtl/lcdc_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module   : lcdc_frame_fetch
// Purpose  : Frame timer / vsync scheduler and burst framebuffer fetch engine
//            feeding the write side of the CSTN LCD controller pixel FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module lcdc_frame_fetch #(
   parameter int ADDR_W          = 24,
   parameter int WORDS_PER_FRAME = 19200,
   parameter int BURST_LEN       = 8,
   parameter int FRAME_PERIOD    = 400000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [ADDR_W-1:0] fb_base,
   output logic              vsync_out,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [47:0]       mem_rdata,
   input  logic              fifo_afull,
   output logic              fifo_we,
   output logic [47:0]       fifo_wdata,
   output logic              busy,
   output logic              overrun,
   input  logic              overrun_clr
);

   localparam int c_TIMER_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
   localparam int c_WORDS_W = $clog2(WORDS_PER_FRAME + 1);
   localparam int c_BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(FRAME_PERIOD - 1);
   // Word count at the start of the final burst of a frame
   localparam logic [c_WORDS_W-1:0] c_WORDS_LAST = c_WORDS_W'(WORDS_PER_FRAME - BURST_LEN);
   localparam logic [c_WORDS_W-1:0] c_WORDS_STEP = c_WORDS_W'(BURST_LEN);
   localparam logic [c_BEAT_W-1:0]  c_BEAT_LAST  = c_BEAT_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0]    c_ADDR_STEP  = ADDR_W'(BURST_LEN);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_SPACE = 2'd1,
      ST_REQ        = 2'd2,
      ST_DATA       = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_TIMER_W-1:0] r_timer;
   logic [ADDR_W-1:0]    r_addr;
   logic [c_WORDS_W-1:0] r_words;
   logic [c_BEAT_W-1:0]  r_beat;
   logic                 w_expiry;
   logic                 w_frame_start;
   logic                 w_beat;
   logic                 w_burst_done;
   logic                 w_last_burst;

   assign w_expiry      = enable && (r_timer == c_TIMER_LAST);
   assign w_frame_start = w_expiry && (r_state == ST_IDLE);
   assign w_beat        = (r_state == ST_DATA) && mem_rvalid;
   assign w_burst_done  = w_beat && (r_beat == c_BEAT_LAST);
   assign w_last_burst  = (r_words == c_WORDS_LAST);

   assign vsync_out = w_frame_start;
   assign mem_addr  = r_addr;
   assign busy      = (r_state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (!enable || (r_timer == c_TIMER_LAST)) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_req     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_frame_start) w_state_nxt = ST_WAIT_SPACE;
         end
         ST_WAIT_SPACE: begin
            if (!enable)          w_state_nxt = ST_IDLE;
            else if (!fifo_afull) w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            mem_req = 1'b1;
            if (mem_gnt) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            // A granted burst always runs to completion, even with enable low
            if (w_burst_done) begin
               if (w_last_burst || !enable) w_state_nxt = ST_IDLE;
               else                         w_state_nxt = ST_WAIT_SPACE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_words <= '0;
         r_beat  <= '0;
      end else if (w_frame_start) begin
         r_addr  <= fb_base;
         r_words <= '0;
         r_beat  <= '0;
      end else if (w_beat) begin
         if (r_beat == c_BEAT_LAST) begin
            r_beat  <= '0;
            r_addr  <= r_addr + c_ADDR_STEP;
            r_words <= r_words + c_WORDS_STEP;
         end else begin
            r_beat  <= r_beat + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_we    <= 1'b0;
         fifo_wdata <= '0;
      end else begin
         fifo_we <= w_beat;
         if (w_beat) fifo_wdata <= mem_rdata;
      end
   end

   // Set has priority over a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else if (w_expiry && (r_state != ST_IDLE)) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

endmodule
`default_nettype wire
